// File: rtl/keyvalue_pkg.sv
// Shared defaults and FSM state encoding for the key/value store arbiter.
package keyvalue_pkg;

    localparam int KEY_W_DEF   = 8;
    localparam int VAL_W_DEF   = 16;
    localparam int TIMEOUT_DEF = 64;
    localparam int CNT_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } kv_state_e;

endpackage

// File: rtl/keyvalue_arbiter_rr.sv
// Two-way round-robin grant: pointer picks the winner on contention and
// moves to the losing side when the owning transaction completes.
module rr_arbiter2 (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    input  logic       adv_i,
    output logic [1:0] gnt_o,
    output logic       owner_o
);

    logic ptr_q, ptr_d;
    logic owner_q, owner_d;

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = ptr_q ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        owner_d = owner_q;
        ptr_d   = ptr_q;
        if (accept_i) begin
            owner_d = gnt_o[1];
        end
        // owner_q is stable through BUSY/RESP, so the loser is simply its inverse
        if (adv_i) begin
            ptr_d = ~owner_q;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ptr_q   <= 1'b0;
            owner_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    assign owner_o = owner_q;

endmodule

// File: rtl/keyvalue_arbiter.sv
// Arbitrates two requesters onto a single key/value store port, one
// transaction at a time, with a store-acknowledge timeout.
//
// state | meaning
// IDLE  | no transaction; accept the granted request
// BUSY  | strobe the store with the registered request, wait for ack/timeout
// RESP  | pulse done to the owner with captured rdata/hit/err
module keyvalue_arbiter
    import keyvalue_pkg::*;
#(
    parameter int KEY_W   = KEY_W_DEF,
    parameter int VAL_W   = VAL_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,

    input  logic             r0_req,
    input  logic             r0_we,
    input  logic [KEY_W-1:0] r0_key,
    input  logic [VAL_W-1:0] r0_wdata,
    output logic             r0_done,
    output logic [VAL_W-1:0] r0_rdata,
    output logic             r0_hit,
    output logic             r0_err,

    input  logic             r1_req,
    input  logic             r1_we,
    input  logic [KEY_W-1:0] r1_key,
    input  logic [VAL_W-1:0] r1_wdata,
    output logic             r1_done,
    output logic [VAL_W-1:0] r1_rdata,
    output logic             r1_hit,
    output logic             r1_err,

    output logic             kv_stb_o,
    output logic             kv_we_o,
    output logic [KEY_W-1:0] kv_key_o,
    output logic [VAL_W-1:0] kv_val_o,
    input  logic             kv_ack_i,
    input  logic [VAL_W-1:0] kv_val_i,
    input  logic             kv_hit_i,

    output logic             busy_o
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    kv_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic [VAL_W-1:0] wdata_q, wdata_d;
    logic [VAL_W-1:0] rdata_q [2];
    logic [VAL_W-1:0] rdata_d [2];
    logic [1:0]       hit_q, hit_d;
    logic [1:0]       err_q, err_d;

    logic [1:0]       gnt;
    logic             owner;
    logic             accept;
    logic             adv;

    rr_arbiter2 u_arb (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .req_i     ({r1_req, r0_req}),
        .accept_i  (accept),
        .adv_i     (adv),
        .gnt_o     (gnt),
        .owner_o   (owner)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        key_d      = key_q;
        wdata_d    = wdata_q;
        rdata_d[0] = rdata_q[0];
        rdata_d[1] = rdata_q[1];
        hit_d      = hit_q;
        err_d      = err_q;
        accept     = 1'b0;
        adv        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (r0_req || r1_req) begin
                    accept  = 1'b1;
                    we_d    = gnt[1] ? r1_we    : r0_we;
                    key_d   = gnt[1] ? r1_key   : r0_key;
                    wdata_d = gnt[1] ? r1_wdata : r0_wdata;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // ack is tested first so a coincident timeout never flags err
                if (kv_ack_i) begin
                    rdata_d[owner] = we_q ? '0 : kv_val_i;
                    hit_d[owner]   = kv_hit_i;
                    err_d[owner]   = 1'b0;
                    state_d        = ST_RESP;
                end else if (cnt_q == TO_LAST) begin
                    rdata_d[owner] = '0;
                    hit_d[owner]   = 1'b0;
                    err_d[owner]   = 1'b1;
                    state_d        = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                adv     = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            we_q       <= 1'b0;
            key_q      <= '0;
            wdata_q    <= '0;
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
            hit_q      <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            key_q      <= key_d;
            wdata_q    <= wdata_d;
            rdata_q[0] <= rdata_d[0];
            rdata_q[1] <= rdata_d[1];
            hit_q      <= hit_d;
            err_q      <= err_d;
        end
    end

    assign busy_o   = (state_q != ST_IDLE);
    assign kv_stb_o = (state_q == ST_BUSY);
    assign kv_we_o  = kv_stb_o & we_q;
    assign kv_key_o = kv_stb_o ? key_q   : '0;
    assign kv_val_o = kv_stb_o ? wdata_q : '0;

    assign r0_done  = (state_q == ST_RESP) && !owner;
    assign r1_done  = (state_q == ST_RESP) &&  owner;
    assign r0_rdata = rdata_q[0];
    assign r1_rdata = rdata_q[1];
    assign r0_hit   = hit_q[0];
    assign r1_hit   = hit_q[1];
    assign r0_err   = err_q[0];
    assign r1_err   = err_q[1];

endmodule

// File: tb/tb_keyvalue_arbiter.sv
// Directed bench for keyvalue_arbiter: vector table of single transactions
// plus hand sequences for alternation, reset, req drop and stray acks.
module tb_keyvalue_arbiter;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [1:0]  req_v = '0;
    logic [1:0]  we_v = '0;
    logic [7:0]  key_v [2];
    logic [15:0] wd_v [2];
    logic        kv_ack_i = 1'b0;
    logic [15:0] kv_val_i = '0;
    logic        kv_hit_i = 1'b0;

    wire         r0_done, r1_done, r0_hit, r1_hit, r0_err, r1_err;
    wire [15:0]  r0_rdata, r1_rdata;
    wire         kv_stb_o, kv_we_o, busy_o;
    wire [7:0]   kv_key_o;
    wire [15:0]  kv_val_o;

    logic [1:0]  done_v;
    assign done_v = {r1_done, r0_done};

    keyvalue_arbiter #(.KEY_W(8), .VAL_W(16), .TIMEOUT(4)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .r0_req    (req_v[0]),
        .r0_we     (we_v[0]),
        .r0_key    (key_v[0]),
        .r0_wdata  (wd_v[0]),
        .r0_done   (r0_done),
        .r0_rdata  (r0_rdata),
        .r0_hit    (r0_hit),
        .r0_err    (r0_err),
        .r1_req    (req_v[1]),
        .r1_we     (we_v[1]),
        .r1_key    (key_v[1]),
        .r1_wdata  (wd_v[1]),
        .r1_done   (r1_done),
        .r1_rdata  (r1_rdata),
        .r1_hit    (r1_hit),
        .r1_err    (r1_err),
        .kv_stb_o  (kv_stb_o),
        .kv_we_o   (kv_we_o),
        .kv_key_o  (kv_key_o),
        .kv_val_o  (kv_val_o),
        .kv_ack_i  (kv_ack_i),
        .kv_val_i  (kv_val_i),
        .kv_hit_i  (kv_hit_i),
        .busy_o    (busy_o)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // store model: acks in BUSY cycle index ack_dly (0-based), 255 = never
    int          ack_dly = 255;
    logic        ack_force = 1'b0;
    logic [15:0] st_val = '0;
    logic        st_hit = 1'b0;
    int          bcyc = 0;
    int          stb_cnt = 0;
    logic        cap_we;
    logic [7:0]  cap_key;
    logic [15:0] cap_val;

    always @(negedge sys_clk) begin
        if (kv_stb_o) begin
            if (bcyc == 0) begin
                cap_we  = kv_we_o;
                cap_key = kv_key_o;
                cap_val = kv_val_o;
            end
            kv_ack_i = (bcyc == ack_dly);
            stb_cnt++;
            bcyc++;
        end else begin
            kv_ack_i = ack_force;
            bcyc = 0;
        end
        kv_val_i = st_val;
        kv_hit_i = st_hit;
    end

    int dn0 = 0, dn1 = 0;
    bit both_done = 1'b0;
    always @(negedge sys_clk) begin
        if (r0_done) dn0++;
        if (r1_done) dn1++;
        if (r0_done && r1_done) both_done = 1'b1;
    end

    typedef struct {
        int          rq;
        logic        we;
        logic [7:0]  key;
        logic [15:0] wdata;
        int          dly;
        logic [15:0] sval;
        logic        shit;
        logic [15:0] e_rdata;
        logic        e_hit;
        logic        e_err;
        int          e_lat;
        int          e_stb;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [15:0] rdata_of(input int rq);
        return rq ? r1_rdata : r0_rdata;
    endfunction

    task automatic run_vec(input vec_t v);
        int lat;
        bit got;
        logic [15:0] held;
        @(negedge sys_clk);
        ack_dly = v.dly;
        st_val  = v.sval;
        st_hit  = v.shit;
        we_v[v.rq]  = v.we;
        key_v[v.rq] = v.key;
        wd_v[v.rq]  = v.wdata;
        req_v[v.rq] = 1'b1;
        stb_cnt = 0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 50) begin
            @(negedge sys_clk);
            lat++;
            if (done_v[v.rq]) got = 1'b1;
        end
        req_v[v.rq] = 1'b0;
        chk("latency", lat, v.e_lat);
        chk("other_done", done_v[1 - v.rq], 1'b0);
        chk("rdata", rdata_of(v.rq), v.e_rdata);
        chk("hit", v.rq ? r1_hit : r0_hit, v.e_hit);
        chk("err", v.rq ? r1_err : r0_err, v.e_err);
        chk("kv_we", cap_we, v.we);
        chk("kv_key", cap_key, v.key);
        chk("kv_val", cap_val, v.wdata);
        chk("stb_cycles", stb_cnt, v.e_stb);
        held = rdata_of(v.rq);
        @(negedge sys_clk);
        chk("done_one_cycle", done_v[v.rq], 1'b0);
        chk("rdata_hold", rdata_of(v.rq), held);
    endtask

    initial begin
        int who;
        int base0, base1;
        int n;
        bit got;

        //            rq we    key    wdata     dly sval      hit   e_rdata   e_hit e_err lat stb
        vecs[0] = '{0, 1'b0, 8'h12, 16'h0000, 0,   16'hBEEF, 1'b1, 16'hBEEF, 1'b1, 1'b0, 2, 1};
        vecs[1] = '{1, 1'b1, 8'h05, 16'h1234, 255, 16'h9999, 1'b1, 16'h0000, 1'b0, 1'b1, 5, 4};
        vecs[2] = '{1, 1'b0, 8'h33, 16'h0000, 2,   16'h0A0A, 1'b0, 16'h0A0A, 1'b0, 1'b0, 4, 3};
        vecs[3] = '{0, 1'b1, 8'h44, 16'h5555, 1,   16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0, 3, 2};
        vecs[4] = '{0, 1'b0, 8'h07, 16'h0000, 3,   16'hCAFE, 1'b1, 16'hCAFE, 1'b1, 1'b0, 5, 4};
        vecs[5] = '{1, 1'b0, 8'h21, 16'h0000, 4,   16'h7777, 1'b1, 16'h0000, 1'b0, 1'b1, 5, 4};

        key_v[0] = '0; key_v[1] = '0;
        wd_v[0]  = '0; wd_v[1]  = '0;

        repeat (3) @(negedge sys_clk);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_stb", kv_stb_o, 1'b0);
        chk("rst_done", done_v, 2'b00);
        chk("rst_rdata0", r0_rdata, 16'h0);
        chk("rst_flags", {r0_hit, r0_err, r1_hit, r1_err}, 4'h0);
        sys_rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // both requesting continuously: grants alternate starting at r0
        @(negedge sys_clk);
        ack_dly = 1;
        st_val = 16'h4242;
        we_v = 2'b00;
        base0 = dn0; base1 = dn1;
        req_v = 2'b11;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            got = 1'b0;
            while (!got && n < 20) begin
                @(negedge sys_clk);
                n++;
                if (done_v != 2'b00) got = 1'b1;
            end
            who = done_v[1] ? 1 : 0;
            chk("alt_got_done", got, 1'b1);
            chk("alt_order", who, k % 2);
        end
        req_v = 2'b00;
        @(negedge sys_clk);
        chk("alt_count0", dn0 - base0, 2);
        chk("alt_count1", dn1 - base1, 2);

        // r0 drops req one cycle after grant; transaction still completes
        ack_dly = 2;
        st_val = 16'h1111;
        base0 = dn0;
        key_v[0] = 8'h66;
        we_v[0] = 1'b0;
        req_v[0] = 1'b1;
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk("drop_busy", busy_o, 1'b1);
        req_v[0] = 1'b0;
        repeat (8) @(negedge sys_clk);
        chk("drop_done_once", dn0 - base0, 1);
        chk("drop_rdata", r0_rdata, 16'h1111);
        chk("drop_key", cap_key, 8'h66);

        // acks while idle must not start or complete anything
        base0 = dn0; base1 = dn1;
        ack_force = 1'b1;
        repeat (3) @(negedge sys_clk);
        chk("stray_ack_busy", busy_o, 1'b0);
        ack_force = 1'b0;
        @(negedge sys_clk);
        chk("stray_ack_done", (dn0 - base0) + (dn1 - base1), 0);

        // reset in BUSY: outputs clear at once, no done afterwards
        ack_dly = 255;
        st_val = 16'h2222;
        req_v[0] = 1'b1;
        @(negedge sys_clk);
        @(negedge sys_clk);
        chk("rst_pre_stb", kv_stb_o, 1'b1);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("mid_rst_stb", kv_stb_o, 1'b0);
        chk("mid_rst_busy", busy_o, 1'b0);
        chk("mid_rst_kv", {kv_we_o, kv_key_o, kv_val_o}, 25'h0);
        chk("mid_rst_rdata", r0_rdata, 16'h0);
        req_v[0] = 1'b0;
        base0 = dn0; base1 = dn1;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (6) @(negedge sys_clk);
        chk("post_rst_no_done", (dn0 - base0) + (dn1 - base1), 0);
        ack_dly = 0;
        st_val = 16'h3333;
        req_v = 2'b11;
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge sys_clk);
            n++;
            if (done_v != 2'b00) got = 1'b1;
        end
        req_v = 2'b00;
        chk("post_rst_got", got, 1'b1);
        chk("post_rst_winner", done_v, 2'b01);
        repeat (2) @(negedge sys_clk);

        chk("never_double_done", both_done, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
